// File: rtl/p_bit_pkg.sv
// Shared constants and the xorshift32 step function for the p-bit and its RNG.
package p_bit_pkg;

    localparam int unsigned FRAC_W     = 3;   // Q4.3 input fraction bits
    localparam int unsigned SAT_THRESH = 32;  // |I_i| at which tanh saturates
    localparam int unsigned FULL_SCALE = 127; // activation magnitude at saturation

    localparam int unsigned XS_A = 13;
    localparam int unsigned XS_B = 17;
    localparam int unsigned XS_C = 5;

    function automatic logic [31:0] xorshift32(input logic [31:0] x);
        logic [31:0] y;
        y = x ^ (x << XS_A);
        y = y ^ (y >> XS_B);
        y = y ^ (y << XS_C);
        return y;
    endfunction

endpackage

// File: rtl/p_bit_rng.sv
// xorshift32 generator with enable and reset-time seed load (zero seed replaced).
module p_bit_rng
    import p_bit_pkg::*;
#(
    parameter logic [31:0] SEED_ZERO_SUB = 32'h0000_0001
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [31:0] seed,
    output logic [7:0]  sample
);

    logic [31:0] state_q;
    logic [31:0] load_val;

    // Zero is a fixed point of xorshift, so it must never be loaded.
    assign load_val = (seed == 32'd0) ? SEED_ZERO_SUB : seed;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= load_val;
        end else if (enable) begin
            state_q <= xorshift32(state_q);
        end
    end

    assign sample = state_q[7:0];

endmodule

// File: rtl/p_bit.sv
// Probabilistic bit: m_i <= (round(127*tanh(I_i/8)) > signed random byte) on each enabled edge.
module p_bit
    import p_bit_pkg::*;
#(
    parameter logic [31:0] SEED_ZERO_SUB = 32'h0000_0001
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [7:0]  I_i,
    input  logic [31:0] seed,
    output logic        m_i
);

    // round(127*tanh(k/8)) for k = 0..31; entries from 25 upward are already full scale.
    function automatic logic [6:0] act_lut(input logic [4:0] k);
        logic [6:0] v;
        case (k)
            5'd0:    v = 7'd0;
            5'd1:    v = 7'd16;
            5'd2:    v = 7'd31;
            5'd3:    v = 7'd46;
            5'd4:    v = 7'd59;
            5'd5:    v = 7'd70;
            5'd6:    v = 7'd81;
            5'd7:    v = 7'd89;
            5'd8:    v = 7'd97;
            5'd9:    v = 7'd103;
            5'd10:   v = 7'd108;
            5'd11:   v = 7'd112;
            5'd12:   v = 7'd115;
            5'd13:   v = 7'd118;
            5'd14:   v = 7'd120;
            5'd15:   v = 7'd121;
            5'd16:   v = 7'd122;
            5'd17:   v = 7'd123;
            5'd18:   v = 7'd124;
            5'd19:   v = 7'd125;
            5'd20:   v = 7'd125;
            5'd21:   v = 7'd126;
            5'd22:   v = 7'd126;
            5'd23:   v = 7'd126;
            5'd24:   v = 7'd126;
            default: v = 7'd127;
        endcase
        return v;
    endfunction

    logic              neg;
    logic [7:0]        mag;
    logic [6:0]        pos_act;
    logic [7:0]        pos_ext;
    logic signed [7:0] t_act;
    logic [7:0]        sample;
    logic              fire;

    assign neg = I_i[7];
    // -(-128) wraps to 8'd128, which still reads as saturated when unsigned.
    assign mag = neg ? 8'(-I_i) : I_i;

    always_comb begin
        pos_act = act_lut(mag[4:0]);
        if (mag >= 8'(SAT_THRESH)) begin
            pos_act = 7'(FULL_SCALE);
        end
    end

    assign pos_ext = {1'b0, pos_act};
    assign t_act   = neg ? $signed(8'(-pos_ext)) : $signed(pos_ext);
    assign fire    = t_act > $signed(sample);

    p_bit_rng #(
        .SEED_ZERO_SUB(SEED_ZERO_SUB)
    ) u_rng (
        .clk    (clk),
        .reset_n(reset_n),
        .enable (enable),
        .seed   (seed),
        .sample (sample)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_i <= 1'b0;
        end else if (enable) begin
            m_i <= fire;
        end
    end

endmodule

// File: tb/tb_p_bit.sv
// Self-checking bench for p_bit: tanh/xorshift reference model plus directed and statistical checks.
module tb_p_bit;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              enable;
    logic signed [7:0] I_i;
    logic [31:0]       seed;
    logic              m_i;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    logic [31:0] ms;
    logic        mm;

    always #5 clk = ~clk;

    p_bit dut (
        .clk    (clk),
        .reset_n(reset_n),
        .enable (enable),
        .I_i    (I_i),
        .seed   (seed),
        .m_i    (m_i)
    );

    function automatic logic [31:0] ref_xs(input logic [31:0] x);
        logic [31:0] y;
        y = x ^ (x << 13);
        y = y ^ (y >> 17);
        y = y ^ (y << 5);
        return y;
    endfunction

    function automatic int ref_t(input int i);
        real v;
        if (i >= 32) return 127;
        if (i <= -32) return -127;
        v = $tanh(i / 8.0) * 127.0;
        if (v >= 0.0) return $rtoi(v + 0.5);
        return -$rtoi(-v + 0.5);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h) at %0t",
                     name, $signed(act), act, $signed(exp), exp, $time);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected range %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Reference model, updated in step with the DUT.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ms = (seed == 32'd0) ? 32'h0000_0001 : seed;
            mm = 1'b0;
        end else if (enable) begin
            mm = (ref_t(int'(I_i)) > int'($signed(ms[7:0])));
            ms = ref_xs(ms);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_i_model", {31'd0, m_i}, {31'd0, mm});
            check("state_model", dut.u_rng.state_q, ms);
        end
    end

    task automatic drive(input logic en, input logic signed [7:0] i);
        @(negedge clk);
        #1;
        enable = en;
        I_i    = i;
    endtask

    task automatic edge_settle();
        @(posedge clk);
        #1;
    endtask

    int ones;
    logic signed [7:0] t_seen [256];

    initial begin
        reset_n = 1'b0;
        enable  = 1'b0;
        I_i     = 8'sd0;
        seed    = 32'h0000_0001;
        repeat (2) @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        #1;
        check("reset_state", dut.u_rng.state_q, 32'h0000_0001);
        check("reset_m", {31'd0, m_i}, 32'd0);

        // First update: r=+1, T=0 -> 0
        reset_n = 1'b1;
        enable  = 1'b1;
        I_i     = 8'sd0;
        edge_settle();
        enable = 1'b0;
        check("first_m", {31'd0, m_i}, 32'd0);
        check("first_state", dut.u_rng.state_q, 32'h0004_2021);

        // Second update: r=+33, T=97 -> 1
        drive(1'b1, 8'sd8);
        check("second_r", {24'd0, dut.u_rng.state_q[7:0]}, 32'h21);
        edge_settle();
        enable = 1'b0;
        check("second_m", {31'd0, m_i}, 32'd1);

        // Activation reference points and model pins
        I_i = 8'sd4;   #1; check("t_p4", 32'(dut.t_act), 32'(59));
        I_i = 8'sd8;   #1; check("t_p8", 32'(dut.t_act), 32'(97));
        I_i = 8'sd16;  #1; check("t_p16", 32'(dut.t_act), 32'(122));
        I_i = -8'sd8;  #1; check("t_m8", 32'(dut.t_act), -32'sd97);
        I_i = -8'sd128; #1; check("t_m128", 32'(dut.t_act), -32'sd127);
        check("model_pin16", 32'(ref_t(16)), 32'(122));

        // Sweep all inputs with enable low
        for (int i = -128; i < 128; i++) begin
            I_i = 8'(i);
            #1;
            t_seen[i + 128] = dut.t_act;
            check("t_sweep", 32'(dut.t_act), 32'(ref_t(i)));
        end
        for (int i = 1; i < 128; i++) begin
            check("t_odd", 32'(t_seen[i + 128]), 32'(-int'(t_seen[128 - i])));
        end

        // Seed change while running has no effect
        drive(1'b1, 8'sd20);
        seed = 32'hCAFE_F00D;
        repeat (5) edge_settle();
        drive(1'b0, 8'sd0);

        // Zero seed substitution and hold with enable low
        seed = 32'd0;
        @(negedge clk); #1;
        reset_n = 1'b0;
        repeat (2) edge_settle();
        reset_n = 1'b1;
        repeat (10) edge_settle();
        check("zero_seed_state", dut.u_rng.state_q, 32'h0000_0001);
        check("zero_seed_m", {31'd0, m_i}, 32'd0);

        // Asynchronous reset mid-operation
        seed = 32'hDEAD_BEEF;
        drive(1'b1, 8'sd127);
        repeat (3) edge_settle();
        #2;
        reset_n = 1'b0;
        #1;
        check("async_m", {31'd0, m_i}, 32'd0);
        check("async_state", dut.u_rng.state_q, 32'hDEAD_BEEF);
        @(negedge clk); #1;
        reset_n = 1'b1;
        edge_settle();
        check("post_reset_m", {31'd0, m_i}, 32'd1);  // r = 0xEF = -17 < 127
        check("post_reset_state", dut.u_rng.state_q, ref_xs(32'hDEAD_BEEF));

        // Saturated extremes, compared each edge by the model
        drive(1'b1, 8'sd127);
        repeat (1000) edge_settle();
        drive(1'b1, -8'sd128);
        repeat (1000) edge_settle();

        // Statistics
        drive(1'b1, 8'sd8);
        ones = 0;
        repeat (10000) begin
            edge_settle();
            ones += int'(m_i);
        end
        check_range("frac_i8", ones, 8600, 9000);

        drive(1'b1, 8'sd0);
        ones = 0;
        repeat (10000) begin
            edge_settle();
            ones += int'(m_i);
        end
        check_range("frac_i0", ones, 4800, 5200);

        drive(1'b0, 8'sd0);
        @(negedge clk);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/p_bit.md
P_BIT -- requirements
Module: p_bit

Interface
REQ-001 Parameter SEED_ZERO_SUB, default 32'h0000_0001: RNG seed substituted when the seed input is all-zero.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 enable  input  1  update strobe; when high, the block performs one p-bit update on the rising clk edge.
REQ-005 I_i  input  8  signed effective input, Q4.3 format (value = I_i/8, range -16.0..+15.875).
REQ-006 seed  input  32  RNG seed, sampled only while reset_n is low.
REQ-007 m_i  output  1  p-bit state (1 = +1, 0 = -1), registered.

Function
REQ-008 p_bit SHALL hold a 32-bit RNG state S and the registered output m_i; no other architectural state.
REQ-009 Activation T SHALL be a signed 8-bit value equal to round(127*tanh(I_i/8)), computed combinationally from I_i.
REQ-010 For |I_i| >= 32 (|x| >= 4.0), T SHALL saturate to +127 for positive I_i and -127 for negative I_i; I_i = -128 SHALL give T = -127.
REQ-011 T SHALL be odd-symmetric: T(-I) = -T(I) for every I in -127..127; T(0) = 0.
REQ-012 Reference points: T(4)=59, T(8)=97, T(16)=122, T(-8)=-97.
REQ-013 Random sample r SHALL be S[7:0] interpreted as signed 8-bit, taken from the current (pre-advance) state.
REQ-014 On a rising clk edge with enable=1: m_i <= 1 if T > r (signed compare), else 0; latency is one clock edge.
REQ-015 On the same edge, S SHALL advance by one xorshift32 step: x ^= x<<13; x ^= x>>17; x ^= x<<5 (32-bit, logical shifts).
REQ-016 With enable=0, m_i and S SHALL hold their values; I_i is ignored.
REQ-017 The RNG state SHALL never be zero; xorshift32 preserves non-zero state, so only the reset load needs the REQ-019 substitution.
REQ-018 Back-to-back enable cycles SHALL each produce an independent update using the then-current I_i and S.

Reset
REQ-019 While reset_n is low, S SHALL be loaded with seed, or with SEED_ZERO_SUB if seed == 0, and m_i SHALL be 0.
REQ-020 Reset asserted mid-operation SHALL immediately (asynchronously) force m_i to 0 and reload S; the first enabled edge after release uses the freshly loaded S.
REQ-021 A change on seed while reset_n is high SHALL have no effect.

Structure
REQ-022 Shared package p_bit_pkg SHALL hold: the Q4.3 fraction width (3), the activation saturation threshold (32), the activation full-scale (127), and the xorshift shift constants (13, 17, 5).
REQ-023 The 32-entry activation table for |I_i| = 0..31 SHALL be a constant function or case in p_bit; negative inputs use the negated magnitude entry.
REQ-024 The RNG SHALL be one sub-module p_bit_rng (xorshift32 with enable, reset-load, and zero-seed substitution) instantiated once in p_bit.

Verification
REQ-025 Reset with seed=32'h1, release, enable=1 for one edge with I_i=0 -> r=+1, T=0, m_i=0; S becomes 32'h0004_2021.
REQ-026 Continue from REQ-025: enable one edge with I_i=8 -> r=+33 (S[7:0]=8'h21), T=97, m_i=1.
REQ-027 seed=0, reset -> S loads 32'h0000_0001; with enable=0 for 10 cycles, m_i stays 0 and S is unchanged.
REQ-028 I_i=+127 for 1000 enabled edges -> m_i=1 every edge except when r >= 127; I_i=-128 -> m_i=0 except when r = -128.
REQ-029 Activation sweep with I_i = -128..127 -> T matches round(127*tanh(I/8)), is saturated for |I| >= 32, and is odd-symmetric.
REQ-030 Statistics: I_i=8 over 10,000 enabled edges -> fraction of m_i=1 within 0.88 +/- 0.02 (consistent with (97+128)/256); I_i=0 -> 0.50 +/- 0.02.
